pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
- Generic Y86-64 pipeline stage register, instanced between any two stages (F/D, D/E, E/M, M/W).
- Each clock it does one of three things: loads the upstream fields, holds them (stall), or inserts a full NOP bubble with every field cleared.
- Holds saturating stall/bubble event counters and a sticky control-conflict flag for the hazard unit and debug.

Parameters:
WORD_W, 64, width of valC/valA/valB
REG_W, 4, width of register-ID fields (dstE/dstM/srcA/srcB)
CNT_W, 16, width of event counters
NOP_ICODE, 4'h1, icode loaded on bubble/reset
RNONE, 4'hF, register ID loaded into dst/src fields on bubble/reset
SAOK, 3'd1, status code loaded on bubble/reset

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high; forces the bubble state and clears counters/flag
stall  in  1  hold current contents
bubble  in  1  load NOP bubble
in_stat  in  3  upstream status
in_icode  in  4  upstream icode
in_ifun  in  4  upstream ifun
in_valC  in  WORD_W  upstream constant
in_valA  in  WORD_W  upstream valA
in_valB  in  WORD_W  upstream valB
in_dstE, in_dstM, in_srcA, in_srcB  in  REG_W each  upstream register IDs
out_stat, out_icode, out_ifun, out_valC, out_valA, out_valB, out_dstE, out_dstM, out_srcA, out_srcB  out  matching widths  registered fields
out_is_bubble  out  1  current contents are an inserted/reset bubble
stall_cnt  out  CNT_W  cycles held by stall
bubble_cnt  out  CNT_W  bubbles inserted by the bubble input
ctrl_err  out  1  sticky flag: stall and bubble were asserted together

Behaviour:
- Reset (asynchronous, takes effect immediately, independent of clk):
  - stat=SAOK, icode=NOP_ICODE, ifun=0, valC/valA/valB=0.
  - dstE/dstM/srcA/srcB=RNONE.
  - out_is_bubble=1, stall_cnt=0, bubble_cnt=0, ctrl_err=0.
- Reset asserted mid-operation discards the held instruction. The first edge after reset deasserts behaves normally.
- Per rising edge, when reset=0, priority order is:
  - bubble=1: load the bubble state, the same values as reset. out_is_bubble=1. bubble_cnt += 1.
  - bubble=0, stall=1: all fields and out_is_bubble hold. stall_cnt += 1.
  - Both 0: load all in_* fields. out_is_bubble=0, even if in_icode equals NOP_ICODE.
- Simultaneous stall=1 and bubble=1:
  - Bubble wins.
  - bubble_cnt increments; stall_cnt does not.
  - ctrl_err sets to 1 and stays set until reset.
- Bubble loads every field, not only icode/ifun. This guarantees no stale dst IDs reach the forwarding logic.
- Latency:
  - Load: 1 cycle, in_* to out_*.
  - Stall: 0-cycle hold.
  - No combinational path from inputs to outputs.
- Counters:
  - Unsigned, saturate at 2^CNT_W-1 with no wrap.
  - A saturated counter ignores further events.
- Stall while the stage holds a bubble: the bubble is held, out_is_bubble stays 1, and stall_cnt still counts.
- Bubble on consecutive cycles: each cycle counts.
- All outputs are registers. No X reaches any output after reset.

Test Plan:
1. Assert reset for 2 cycles, then release with stall=bubble=0 and in_icode=6, in_dstE=3, in_valA=64'h10 -> during reset: icode=1, dstE=F, stat=1, out_is_bubble=1, counters 0; first edge after release: icode=6, dstE=3, valA=64'h10, out_is_bubble=0.
2. Load icode=5, srcA=2, then hold stall=1 for 3 cycles while the inputs change -> outputs stay icode=5, srcA=2 throughout; stall_cnt=3.
3. Load icode=3, dstE=4, valC=64'hFF, then pulse bubble=1 for 1 cycle -> icode=1, ifun=0, dstE=F, dstM=F, srcA=F, srcB=F, valC=0, stat=1, out_is_bubble=1, bubble_cnt=1.
4. Assert stall=1 and bubble=1 on the same edge -> bubble state loaded, bubble_cnt +1, stall_cnt unchanged, ctrl_err=1; ctrl_err stays 1 after both drop, clears only on reset.
5. With CNT_W=3, hold stall for 10 cycles -> stall_cnt reads 7 and stays at 7 (no wrap).
6. Assert reset asynchronously between edges while valid data icode=7 is held -> outputs switch to the bubble state immediately, before the next edge; counters 0.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: Y86-64 pipeline stage register with load/stall/bubble control,
// saturating stall/bubble event counters and a sticky stall+bubble conflict flag.
module pipe_stage_reg #(
    parameter int          WORD_W    = 64,
    parameter int          REG_W     = 4,
    parameter int          CNT_W     = 16,
    parameter logic [3:0]  NOP_ICODE = 4'h1,
    parameter logic [REG_W-1:0] RNONE = 4'hF,
    parameter logic [2:0]  SAOK      = 3'd1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              bubble,
    input  logic [2:0]        in_stat,
    input  logic [3:0]        in_icode,
    input  logic [3:0]        in_ifun,
    input  logic [WORD_W-1:0] in_valC,
    input  logic [WORD_W-1:0] in_valA,
    input  logic [WORD_W-1:0] in_valB,
    input  logic [REG_W-1:0]  in_dstE,
    input  logic [REG_W-1:0]  in_dstM,
    input  logic [REG_W-1:0]  in_srcA,
    input  logic [REG_W-1:0]  in_srcB,
    output logic [2:0]        out_stat,
    output logic [3:0]        out_icode,
    output logic [3:0]        out_ifun,
    output logic [WORD_W-1:0] out_valC,
    output logic [WORD_W-1:0] out_valA,
    output logic [WORD_W-1:0] out_valB,
    output logic [REG_W-1:0]  out_dstE,
    output logic [REG_W-1:0]  out_dstM,
    output logic [REG_W-1:0]  out_srcA,
    output logic [REG_W-1:0]  out_srcB,
    output logic              out_is_bubble,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt,
    output logic              ctrl_err
);
    typedef struct packed {
        logic [2:0]        stat;
        logic [3:0]        icode;
        logic [3:0]        ifun;
        logic [WORD_W-1:0] valc;
        logic [WORD_W-1:0] vala;
        logic [WORD_W-1:0] valb;
        logic [REG_W-1:0]  dste;
        logic [REG_W-1:0]  dstm;
        logic [REG_W-1:0]  srca;
        logic [REG_W-1:0]  srcb;
    } fields_t;

    // Every field is cleared so no stale register ID can reach forwarding.
    localparam fields_t BUBBLE_F = '{
        stat: SAOK, icode: NOP_ICODE, ifun: 4'h0,
        valc: '0, vala: '0, valb: '0,
        dste: RNONE, dstm: RNONE, srca: RNONE, srcb: RNONE
    };

    fields_t          in_f, fld_q, fld_d;
    logic             is_bubble_q, is_bubble_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
    logic             ctrl_err_q, ctrl_err_d;
    logic             stall_ev;

    assign in_f = '{
        stat: in_stat, icode: in_icode, ifun: in_ifun,
        valc: in_valC, vala: in_valA, valb: in_valB,
        dste: in_dstE, dstm: in_dstM, srca: in_srcA, srcb: in_srcB
    };
    assign stall_ev = stall && !bubble;

    always_comb begin
        fld_d        = bubble ? BUBBLE_F : stall ? fld_q : in_f;
        is_bubble_d  = bubble ? 1'b1 : stall ? is_bubble_q : 1'b0;
        stall_cnt_d  = (stall_ev && stall_cnt_q != '1) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
        bubble_cnt_d = (bubble && bubble_cnt_q != '1) ? bubble_cnt_q + CNT_W'(1) : bubble_cnt_q;
        ctrl_err_d   = ctrl_err_q || (stall && bubble);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fld_q        <= BUBBLE_F;
            is_bubble_q  <= 1'b1;
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
            ctrl_err_q   <= 1'b0;
        end else begin
            fld_q        <= fld_d;
            is_bubble_q  <= is_bubble_d;
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
            ctrl_err_q   <= ctrl_err_d;
        end
    end

    assign out_stat      = fld_q.stat;
    assign out_icode     = fld_q.icode;
    assign out_ifun      = fld_q.ifun;
    assign out_valC      = fld_q.valc;
    assign out_valA      = fld_q.vala;
    assign out_valB      = fld_q.valb;
    assign out_dstE      = fld_q.dste;
    assign out_dstM      = fld_q.dstm;
    assign out_srcA      = fld_q.srca;
    assign out_srcB      = fld_q.srcb;
    assign out_is_bubble = is_bubble_q;
    assign stall_cnt     = stall_cnt_q;
    assign bubble_cnt    = bubble_cnt_q;
    assign ctrl_err      = ctrl_err_q;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed checks of load/stall/bubble, counters, ctrl_err and async reset,
// plus a CNT_W=3 instance for counter saturation.
module tb_pipe_stage_reg;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0, bubble = 1'b0, stall3 = 1'b0;
    logic [2:0]  in_stat = 3'd0;
    logic [3:0]  in_icode = 4'd0, in_ifun = 4'd0;
    logic [63:0] in_valC = '0, in_valA = '0, in_valB = '0;
    logic [3:0]  in_dstE = 4'd0, in_dstM = 4'd0, in_srcA = 4'd0, in_srcB = 4'd0;

    logic [2:0]  out_stat, s3_stat;
    logic [3:0]  out_icode, out_ifun, s3_icode, s3_ifun;
    logic [63:0] out_valC, out_valA, out_valB, s3_valC, s3_valA, s3_valB;
    logic [3:0]  out_dstE, out_dstM, out_srcA, out_srcB, s3_dstE, s3_dstM, s3_srcA, s3_srcB;
    logic        out_is_bubble, ctrl_err, s3_is_bubble, s3_ctrl_err;
    logic [15:0] stall_cnt, bubble_cnt;
    logic [2:0]  s3_stall_cnt, s3_bubble_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_stage_reg dut (
        .clk(clk), .reset(reset), .stall(stall), .bubble(bubble),
        .in_stat(in_stat), .in_icode(in_icode), .in_ifun(in_ifun),
        .in_valC(in_valC), .in_valA(in_valA), .in_valB(in_valB),
        .in_dstE(in_dstE), .in_dstM(in_dstM), .in_srcA(in_srcA), .in_srcB(in_srcB),
        .out_stat(out_stat), .out_icode(out_icode), .out_ifun(out_ifun),
        .out_valC(out_valC), .out_valA(out_valA), .out_valB(out_valB),
        .out_dstE(out_dstE), .out_dstM(out_dstM), .out_srcA(out_srcA), .out_srcB(out_srcB),
        .out_is_bubble(out_is_bubble), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt),
        .ctrl_err(ctrl_err)
    );

    pipe_stage_reg #(.CNT_W(3)) dut3 (
        .clk(clk), .reset(reset), .stall(stall3), .bubble(1'b0),
        .in_stat(in_stat), .in_icode(in_icode), .in_ifun(in_ifun),
        .in_valC(in_valC), .in_valA(in_valA), .in_valB(in_valB),
        .in_dstE(in_dstE), .in_dstM(in_dstM), .in_srcA(in_srcA), .in_srcB(in_srcB),
        .out_stat(s3_stat), .out_icode(s3_icode), .out_ifun(s3_ifun),
        .out_valC(s3_valC), .out_valA(s3_valA), .out_valB(s3_valB),
        .out_dstE(s3_dstE), .out_dstM(s3_dstM), .out_srcA(s3_srcA), .out_srcB(s3_srcB),
        .out_is_bubble(s3_is_bubble), .stall_cnt(s3_stall_cnt), .bubble_cnt(s3_bubble_cnt),
        .ctrl_err(s3_ctrl_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, ".stat"}, 64'(out_stat), 64'd1);
        chk({tag, ".icode"}, 64'(out_icode), 64'd1);
        chk({tag, ".ifun"}, 64'(out_ifun), 64'd0);
        chk({tag, ".valC"}, out_valC, 64'd0);
        chk({tag, ".valA"}, out_valA, 64'd0);
        chk({tag, ".valB"}, out_valB, 64'd0);
        chk({tag, ".dstE"}, 64'(out_dstE), 64'hF);
        chk({tag, ".dstM"}, 64'(out_dstM), 64'hF);
        chk({tag, ".srcA"}, 64'(out_srcA), 64'hF);
        chk({tag, ".srcB"}, 64'(out_srcB), 64'hF);
        chk({tag, ".is_bubble"}, 64'(out_is_bubble), 64'd1);
    endtask

    initial begin
        // Test 1: reset state, then first load
        in_icode = 4'd6; in_dstE = 4'd3; in_valA = 64'h10;
        #2 reset = 1'b1;
        #1;
        chk_bubble("rst_async");
        chk("rst.stall_cnt", 64'(stall_cnt), 64'd0);
        chk("rst.bubble_cnt", 64'(bubble_cnt), 64'd0);
        chk("rst.ctrl_err", 64'(ctrl_err), 64'd0);
        tick();
        tick();
        chk_bubble("rst_held");
        reset = 1'b0;
        tick();
        chk("t1.icode", 64'(out_icode), 64'd6);
        chk("t1.dstE", 64'(out_dstE), 64'd3);
        chk("t1.valA", out_valA, 64'h10);
        chk("t1.is_bubble", 64'(out_is_bubble), 64'd0);

        // Test 2: stall holds for 3 cycles while inputs change
        in_icode = 4'd5; in_srcA = 4'd2;
        tick();
        chk("t2.load_icode", 64'(out_icode), 64'd5);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_icode = 4'(9 + i); in_srcA = 4'(7 + i);
            tick();
            chk("t2.hold_icode", 64'(out_icode), 64'd5);
            chk("t2.hold_srcA", 64'(out_srcA), 64'd2);
        end
        stall = 1'b0;
        chk("t2.stall_cnt", 64'(stall_cnt), 64'd3);
        chk("t2.bubble_cnt", 64'(bubble_cnt), 64'd0);

        // Test 3: bubble clears every field; NOP icode loaded normally is not a bubble
        in_icode = 4'd3; in_dstE = 4'd4; in_valC = 64'hFF; in_ifun = 4'd2;
        in_dstM = 4'd5; in_srcA = 4'd6; in_srcB = 4'd7; in_stat = 3'd2; in_valB = 64'h55;
        tick();
        chk("t3.icode", 64'(out_icode), 64'd3);
        chk("t3.valC", out_valC, 64'hFF);
        chk("t3.stat", 64'(out_stat), 64'd2);
        bubble = 1'b1;
        tick();
        bubble = 1'b0;
        chk_bubble("t3");
        chk("t3.bubble_cnt", 64'(bubble_cnt), 64'd1);
        chk("t3.stall_cnt", 64'(stall_cnt), 64'd3);
        stall = 1'b1;
        tick();
        stall = 1'b0;
        chk_bubble("t3_stall_on_bubble");
        chk("t3.stall_cnt2", 64'(stall_cnt), 64'd4);
        chk("t3.ctrl_err", 64'(ctrl_err), 64'd0);
        in_icode = 4'd1;
        tick();
        chk("t3.nop_load_is_bubble", 64'(out_is_bubble), 64'd0);

        // Test 4: stall+bubble together
        in_icode = 4'd3;
        tick();
        stall = 1'b1; bubble = 1'b1;
        tick();
        stall = 1'b0; bubble = 1'b0;
        chk_bubble("t4");
        chk("t4.bubble_cnt", 64'(bubble_cnt), 64'd2);
        chk("t4.stall_cnt", 64'(stall_cnt), 64'd4);
        chk("t4.ctrl_err", 64'(ctrl_err), 64'd1);
        in_icode = 4'd2;
        tick();
        chk("t4.icode_after", 64'(out_icode), 64'd2);
        chk("t4.ctrl_err_sticky", 64'(ctrl_err), 64'd1);

        // Consecutive bubbles each count
        bubble = 1'b1;
        tick();
        tick();
        bubble = 1'b0;
        chk("bb.bubble_cnt", 64'(bubble_cnt), 64'd4);

        // Test 5: CNT_W=3 saturation
        stall3 = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk("t5.s3_stall_cnt", 64'(s3_stall_cnt), 64'(i > 7 ? 7 : i));
        end
        stall3 = 1'b0;
        tick();
        chk("t5.s3_stall_cnt_final", 64'(s3_stall_cnt), 64'd7);
        chk("t5.s3_bubble_cnt", 64'(s3_bubble_cnt), 64'd0);

        // Test 6: async reset between edges
        in_icode = 4'd7; in_dstE = 4'd2;
        tick();
        chk("t6.icode", 64'(out_icode), 64'd7);
        #2 reset = 1'b1;
        #1;
        chk_bubble("t6");
        chk("t6.stall_cnt", 64'(stall_cnt), 64'd0);
        chk("t6.bubble_cnt", 64'(bubble_cnt), 64'd0);
        chk("t6.ctrl_err", 64'(ctrl_err), 64'd0);
        chk("t6.s3_stall_cnt", 64'(s3_stall_cnt), 64'd0);
        reset = 1'b0;
        tick();
        chk("t6.reload_icode", 64'(out_icode), 64'd7);
        chk("t6.reload_is_bubble", 64'(out_is_bubble), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
